// File: rtl/zx8x_tape_pkg.sv
// Shared state encoding, default SAVE timing and buffer width for the ZX80/ZX81 tape capture path.
package zx8x_tape_pkg;

  localparam int unsigned TAPE_AW = 14;
  localparam int unsigned QUIET_W = 22;

  typedef logic [1:0] tape_state_t;

  localparam tape_state_t ST_IDLE = 2'd0;
  localparam tape_state_t ST_NAME = 2'd1;
  localparam tape_state_t ST_DATA = 2'd2;
  localparam tape_state_t ST_DONE = 2'd3;

  localparam logic [QUIET_W-1:0] DEF_GAP_CYC  = 22'd15600;
  localparam logic [QUIET_W-1:0] DEF_END_CYC  = 22'd2600000;
  localparam logic [3:0]         DEF_ZERO_MIN = 4'd3;
  localparam logic [3:0]         DEF_ZERO_MAX = 4'd5;
  localparam logic [3:0]         DEF_ONE_MIN  = 4'd7;
  localparam logic [3:0]         DEF_ONE_MAX  = 4'd11;

  function automatic logic in_window(input logic [3:0] cnt, input logic [3:0] lo,
                                     input logic [3:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/zx8x_tape_bitdec.sv
// MIC pulse-train bit decoder: synchronizer, rising-edge detect, pulse/quiet counters and
// pulse-count window classification into 0, 1 or bad bits.
module zx8x_tape_bitdec
  import zx8x_tape_pkg::*;
#(
  parameter logic [QUIET_W-1:0] GAP_CYC  = DEF_GAP_CYC,
  parameter logic [QUIET_W-1:0] END_CYC  = DEF_END_CYC,
  parameter logic [3:0]         ZERO_MIN = DEF_ZERO_MIN,
  parameter logic [3:0]         ZERO_MAX = DEF_ZERO_MAX,
  parameter logic [3:0]         ONE_MIN  = DEF_ONE_MIN,
  parameter logic [3:0]         ONE_MAX  = DEF_ONE_MAX
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic mic,
  output logic pulse_edge,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_err,
  output logic end_quiet
);

  // sync_q[1] is the synchronized level, sync_q[2] its previous value.
  logic [2:0]         sync_q, sync_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic               is_zero, is_one;

  assign pulse_edge = sync_q[1] & ~sync_q[2];
  assign is_zero    = in_window(pulse_q, ZERO_MIN, ZERO_MAX);
  assign is_one     = in_window(pulse_q, ONE_MIN, ONE_MAX);
  // An edge landing on the gap compare restarts the bit instead of closing it.
  assign bit_valid  = (quiet_q == GAP_CYC) && (pulse_q != 4'd0) && !pulse_edge;
  assign bit_val    = is_one;
  assign bit_err    = !is_zero && !is_one;
  assign end_quiet  = (quiet_q == END_CYC);

  always_comb begin
    sync_d  = {sync_q[1:0], mic};
    pulse_d = pulse_q;
    quiet_d = quiet_q;
    if (clr) begin
      pulse_d = 4'd0;
      quiet_d = '0;
    end else if (pulse_edge) begin
      if (pulse_q != 4'hF) pulse_d = pulse_q + 4'd1;
      quiet_d = '0;
    end else begin
      if (bit_valid) pulse_d = 4'd0;
      if (quiet_q != END_CYC) quiet_d = quiet_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 3'b000;
      pulse_q <= 4'd0;
      quiet_q <= '0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
      quiet_q <= quiet_d;
    end
  end

endmodule

// File: rtl/zx8x_tape_saver.sv
// ZX80/ZX81 SAVE capture: assembles decoded bits into bytes and writes them to the tape buffer.
// Define ZX8X_SAVE_NAMESKIP_EN to strip the filename so the buffer holds a pure .p image.
module zx8x_tape_saver
  import zx8x_tape_pkg::*;
#(
  parameter logic [QUIET_W-1:0] GAP_CYC  = DEF_GAP_CYC,
  parameter logic [QUIET_W-1:0] END_CYC  = DEF_END_CYC,
  parameter logic [3:0]         ZERO_MIN = DEF_ZERO_MIN,
  parameter logic [3:0]         ZERO_MAX = DEF_ZERO_MAX,
  parameter logic [3:0]         ONE_MIN  = DEF_ONE_MIN,
  parameter logic [3:0]         ONE_MAX  = DEF_ONE_MAX,
  parameter logic [TAPE_AW-1:0] BUF_LAST = '1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               mic,
  output logic               wr,
  output logic [TAPE_AW-1:0] waddr,
  output logic [7:0]         wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [TAPE_AW-1:0] byte_count,
  output logic [1:0]         state_dbg
);

`ifdef ZX8X_SAVE_NAMESKIP_EN
  localparam tape_state_t CAPTURE_START = ST_NAME;
`else
  localparam tape_state_t CAPTURE_START = ST_DATA;
`endif

  tape_state_t        state_q, state_d;
  logic [2:0]         bits_q, bits_d;
  logic [7:0]         byte_q, byte_d, shifted;
  logic               wr_q, wr_d, err_q, err_d;
  logic [TAPE_AW-1:0] waddr_q, waddr_d, count_q, count_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               pulse_edge, bit_valid, bit_val, bit_err, end_quiet, dec_clr;

  // Counters stay cleared while disarmed or idle; the arming edge itself is the first pulse.
  assign dec_clr = !arm || ((state_q == ST_IDLE) && !pulse_edge);

  zx8x_tape_bitdec #(
    .GAP_CYC (GAP_CYC),
    .END_CYC (END_CYC),
    .ZERO_MIN(ZERO_MIN),
    .ZERO_MAX(ZERO_MAX),
    .ONE_MIN (ONE_MIN),
    .ONE_MAX (ONE_MAX)
  ) u_bitdec (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .clr       (dec_clr),
    .mic       (mic),
    .pulse_edge(pulse_edge),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .bit_err   (bit_err),
    .end_quiet (end_quiet)
  );

  assign shifted = {byte_q[6:0], bit_val};

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    byte_d  = byte_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    count_d = count_q;
    if (wr_q && (count_q != '1)) count_d = count_q + 1'b1;
    if (!arm) begin
      state_d = ST_IDLE;
      bits_d  = 3'd0;
      byte_d  = 8'd0;
      err_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bits_d = 3'd0;
          byte_d = 8'd0;
          if (pulse_edge) state_d = CAPTURE_START;
        end
        ST_NAME, ST_DATA: begin
          if (end_quiet) begin
            state_d = ST_DONE;
            if (bits_q != 3'd0) err_d = 1'b1;
            bits_d = 3'd0;
            byte_d = 8'd0;
          end else if (bit_valid) begin
            if (bit_err) begin
              err_d  = 1'b1;
              bits_d = 3'd0;
              byte_d = 8'd0;
            end else if (bits_q == 3'd7) begin
              bits_d = 3'd0;
              byte_d = 8'd0;
`ifdef ZX8X_SAVE_NAMESKIP_EN
              // The last filename character carries the inverse-video bit.
              if (state_q == ST_NAME) begin
                if (shifted[7]) state_d = ST_DATA;
              end else
`endif
              begin
                wr_d    = 1'b1;
                waddr_d = count_q;
                wdata_d = shifted;
                if (count_q == BUF_LAST) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
                end
              end
            end else begin
              bits_d = bits_q + 3'd1;
              byte_d = shifted;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bits_q  <= 3'd0;
      byte_q  <= 8'd0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Write port: wr is a single-cycle strobe, waddr/wdata are valid only while wr is high;
  // the buffer RAM must accept every strobe (no back-pressure).
  assign wr         = wr_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign err        = err_q;
  assign byte_count = count_q;
  assign busy       = (state_q == ST_NAME) || (state_q == ST_DATA);
  assign done       = (state_q == ST_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_zx8x_tape_saver.sv
// Bench for zx8x_tape_saver: random pulse trains, byte-stream reference model, write scoreboard.
module tb_zx8x_tape_saver;

  localparam int GAP_I = 24;
  localparam int END_I = 200;
  localparam int BUF_I = 5;
`ifdef ZX8X_SAVE_NAMESKIP_EN
  localparam bit NAMESKIP = 1'b1;
`else
  localparam bit NAMESKIP = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        mic = 1'b0;
  logic        wr, busy, done, err;
  logic [13:0] waddr, byte_count;
  logic [7:0]  wdata;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  bit end_chk = 1'b0;
  int model_writes = 0;
  bit model_ovf = 1'b0;
  logic [21:0] exp_q[$];

  zx8x_tape_saver #(
    .GAP_CYC (22'(GAP_I)),
    .END_CYC (22'(END_I)),
    .ZERO_MIN(4'd3),
    .ZERO_MAX(4'd5),
    .ONE_MIN (4'd7),
    .ONE_MAX (4'd11),
    .BUF_LAST(14'(BUF_I))
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .arm       (arm),
    .mic       (mic),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .byte_count(byte_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Which bytes of a sent stream land in the buffer, and where.
  task automatic model_stream(input bq_t b, input int bad_idx);
    bit naming;
    int addr;
    naming = NAMESKIP;
    addr = 0;
    model_writes = 0;
    model_ovf = 1'b0;
    foreach (b[i]) begin
      if (i == bad_idx || model_ovf) continue;
      if (naming) begin
        if (b[i][7]) naming = 1'b0;
        continue;
      end
      exp_q.push_back({addr[13:0], b[i]});
      model_writes++;
      if (addr == BUF_I) model_ovf = 1'b1;
      addr++;
    end
  endtask

  // ---------------- drivers (all start and end just after a negedge) ----------------
  task automatic send_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      mic = 1'b1;
      last_rise = cyc;
      repeat ($urandom_range(1, 3)) @(negedge clk_sys);
      mic = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk_sys);
    end
  endtask

  task automatic send_bit_n(input int n);
    send_pulses(n);
    repeat (GAP_I + $urandom_range(6, 20)) @(negedge clk_sys);
  endtask

  function automatic int pulses_for(input logic v);
    return v ? int'($urandom_range(7, 11)) : int'($urandom_range(3, 5));
  endfunction

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit_n(pulses_for(b[k]));
  endtask

  task automatic send_stream(input bq_t b, input int bad_idx, input int bad_bits, input int bad_cnt);
    foreach (b[i]) begin
      if (i == bad_idx) begin
        for (int k = 0; k < bad_bits; k++) send_bit_n(pulses_for(b[i][7-k]));
        send_bit_n(bad_cnt);
      end else begin
        send_byte(b[i]);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < END_I + 100; i++) begin
      if (done) break;
      @(negedge clk_sys);
    end
  endtask

  task automatic drop_arm();
    arm = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  // ---------------- scoreboard / write monitor ----------------
  task automatic monitor();
    logic prev_wr = 1'b0;
    logic prev_done = 1'b0;
    logic [13:0] prev_addr = '0;
    logic [21:0] exp;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_wr = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (wr) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got addr=%0d data=%h want no write", waddr, wdata);
          end else begin
            exp = exp_q.pop_front();
            if ({waddr, wdata} !== exp)
              begin errors++; $display("FAIL wr_data got addr=%0d data=%h want addr=%0d data=%h",
                                       waddr, wdata, exp[21:8], exp[7:0]); end
          end
          checks++;
          if (cyc != last_rise + GAP_I + 4) begin
            errors++;
            $display("FAIL wr_latency got=%0d want=%0d", cyc - last_rise, GAP_I + 4);
          end
        end
        if (prev_wr) begin
          checks++;
          if (wr !== 1'b0) begin errors++; $display("FAIL wr_width got=%b want=0", wr); end
          checks++;
          if (byte_count !== prev_addr + 14'd1) begin
            errors++;
            $display("FAIL count_update got=%0d want=%0d", byte_count, prev_addr + 14'd1);
          end
        end
        if (done && !prev_done && end_chk) begin
          checks++;
          if (cyc != last_rise + END_I + 4) begin
            errors++;
            $display("FAIL done_latency got=%0d want=%0d", cyc - last_rise, END_I + 4);
          end
        end
        prev_wr = wr;
        prev_addr = waddr;
        prev_done = done;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({wr, waddr, wdata, busy, done, err, byte_count, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b a=%0d d=%h b=%b dn=%b e=%b c=%0d s=%0d want all 0",
               wr, waddr, wdata, busy, done, err, byte_count, state_dbg);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({wr, busy, done, err, byte_count, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_release got wr=%b b=%b dn=%b e=%b c=%0d s=%0d want all 0",
               wr, busy, done, err, byte_count, state_dbg);
    end
  endtask

  task automatic test_plan_stream();
    bq_t s;
    s.push_back(8'hA6); s.push_back(8'h00); s.push_back(8'hFF); s.push_back(8'h5A);
    end_chk = 1'b1;
    model_stream(s, -1);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL plan_busy got=%b want=1", busy); end
    wait_done();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL plan_done got=%b want=1", done); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL plan_err got=%b want=0", err); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL plan_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL plan_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
    checks++;
    if ({busy, done, byte_count, state_dbg} !== '0) begin
      errors++;
      $display("FAIL plan_idle got b=%b dn=%b c=%0d s=%0d want all 0", busy, done, byte_count, state_dbg);
    end
  endtask

  task automatic test_random_windows();
    bq_t s;
    s.push_back(8'hA6);
    for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
    end_chk = 1'b1;
    model_stream(s, -1);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    wait_done();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rand_done got=%b want=1", done); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rand_err got=%b want=0", err); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL rand_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
  endtask

  task automatic test_bad_bit();
    bq_t s;
    int bad_counts[5] = '{1, 2, 6, 12, 16};
    int bad_cnt;
    int bad_bits;
    s.push_back(8'hA6);
    for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
    bad_cnt = bad_counts[$urandom_range(0, 4)];
    bad_bits = $urandom_range(0, 7);
    end_chk = 1'b1;
    model_stream(s, 2);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, 2, bad_bits, bad_cnt);
    wait_done();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bad_done got=%b want=1", done); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_err cnt=%0d got=%b want=1", bad_cnt, err); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL bad_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bad_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got=%b want=0", err); end
  endtask

  task automatic test_partial_end();
    bq_t s;
    s.push_back(8'hA6);
    s.push_back(8'($urandom));
    end_chk = 1'b1;
    model_stream(s, -1);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    for (int k = 0; k < 3; k++) send_bit_n(pulses_for(1'($urandom)));
    wait_done();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL part_done got=%b want=1", done); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL part_err got=%b want=1", err); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL part_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL part_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
  endtask

  task automatic test_overflow();
    bq_t s;
    s.push_back(8'hA6);
    for (int i = 0; i < BUF_I + 2; i++) s.push_back(8'($urandom));
    end_chk = 1'b0;
    model_stream(s, -1);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    wait_done();
    checks++;
    if (done !== model_ovf) begin errors++; $display("FAIL ovf_done got=%b want=%b", done, model_ovf); end
    checks++;
    if (err !== model_ovf) begin errors++; $display("FAIL ovf_err got=%b want=%b", err, model_ovf); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL ovf_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
  endtask

  task automatic test_arm_drop();
    bq_t s;
    logic [7:0] b;
    int target;
    s.push_back(8'hA6);
    model_stream(s, -1);
    end_chk = 1'b1;
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    b = 8'($urandom);
    for (int k = 7; k >= 1; k--) send_bit_n(pulses_for(b[k]));
    send_pulses(pulses_for(b[0]));
    // Drop arm in exactly the cycle where the 8th bit closes.
    target = last_rise + GAP_I + 3;
    while (cyc < target) @(negedge clk_sys);
    arm = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({busy, done, err, byte_count, state_dbg} !== '0) begin
      errors++;
      $display("FAIL drop_idle got b=%b dn=%b e=%b c=%0d s=%0d want all 0",
               busy, done, err, byte_count, state_dbg);
    end
    repeat (GAP_I + 10) @(negedge clk_sys);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_pending got=%0d want=0", exp_q.size()); end
    s.push_back(8'($urandom));
    s.push_back(8'($urandom));
    model_stream(s, -1);
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    wait_done();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rearm_done got=%b want=1", done); end
    checks++;
    if (byte_count !== 14'(model_writes))
      begin errors++; $display("FAIL rearm_count got=%0d want=%0d", byte_count, model_writes); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rearm_pending got=%0d want=0", exp_q.size()); end
    drop_arm();
  endtask

  task automatic test_async_reset();
    bq_t s;
    s.push_back(8'hA6);
    s.push_back(8'($urandom));
    model_stream(s, -1);
    end_chk = 1'b0;
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_stream(s, -1, 0, 0);
    for (int k = 0; k < 3; k++) send_bit_n(pulses_for(1'($urandom)));
    checks++;
    if (state_dbg !== 2'd2) begin errors++; $display("FAIL arst_pre_state got=%0d want=2", state_dbg); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wr, waddr, wdata, busy, done, err, byte_count, state_dbg} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got wr=%b a=%0d d=%h b=%b dn=%b e=%b c=%0d s=%0d want all 0",
               wr, waddr, wdata, busy, done, err, byte_count, state_dbg);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL arst_pending got=%0d want=0", exp_q.size()); end
    exp_q.delete();
    arm = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_plan_stream();
    test_random_windows();
    test_bad_bit();
    test_partial_end();
    test_overflow();
    test_arm_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
